// File: rtl/seven_seg_pkg.sv
// Seven-segment code constants and decode helper shared by the hex display
// encoder and the sevenseg_to_nibble decoder.
package seven_seg_pkg;

  // Segment masks in the packed vector {A,B,C,D,E,F,G}.
  localparam logic [6:0] SEG_A = 7'b100_0000;
  localparam logic [6:0] SEG_B = 7'b010_0000;
  localparam logic [6:0] SEG_C = 7'b001_0000;
  localparam logic [6:0] SEG_D = 7'b000_1000;
  localparam logic [6:0] SEG_E = 7'b000_0100;
  localparam logic [6:0] SEG_F = 7'b000_0010;
  localparam logic [6:0] SEG_G = 7'b000_0001;

  localparam logic [6:0] CODE_0     = 7'h7E;
  localparam logic [6:0] CODE_1     = 7'h30;
  localparam logic [6:0] CODE_2     = 7'h6D;
  localparam logic [6:0] CODE_3     = 7'h79;
  localparam logic [6:0] CODE_4     = 7'h33;
  localparam logic [6:0] CODE_5     = 7'h5B;
  localparam logic [6:0] CODE_6     = 7'h1F;
  localparam logic [6:0] CODE_7     = 7'h70;
  localparam logic [6:0] CODE_8     = 7'h7F;
  localparam logic [6:0] CODE_9     = 7'h73;
  localparam logic [6:0] CODE_A     = 7'h77;
  localparam logic [6:0] CODE_B     = 7'h1F;
  localparam logic [6:0] CODE_C     = 7'h4E;
  localparam logic [6:0] CODE_D     = 7'h3D;
  localparam logic [6:0] CODE_E     = 7'h4F;
  localparam logic [6:0] CODE_F     = 7'h47;
  localparam logic [6:0] CODE_BLANK = 7'h00;

  typedef enum logic {
    ST_SETTLE,
    ST_LOCKED
  } state_e;

  typedef struct packed {
    logic       error;
    logic [3:0] nibble;
  } decode_t;

  // Pattern to {error, nibble}; anything outside the table (blank included)
  // reports error with nibble 0.
  function automatic decode_t decode_seg(input logic [6:0] seg);
    decode_t r;
    r.error  = 1'b0;
    r.nibble = 4'h0;
    case (seg)
      CODE_0:  r.nibble = 4'h0;
      CODE_1:  r.nibble = 4'h1;
      CODE_2:  r.nibble = 4'h2;
      CODE_3:  r.nibble = 4'h3;
      CODE_4:  r.nibble = 4'h4;
      CODE_5:  r.nibble = 4'h5;
      CODE_6:  r.nibble = 4'h6; // CODE_B shares this pattern and reads back as 6
      CODE_7:  r.nibble = 4'h7;
      CODE_8:  r.nibble = 4'h8;
      CODE_9:  r.nibble = 4'h9;
      CODE_A:  r.nibble = 4'hA;
      CODE_C:  r.nibble = 4'hC;
      CODE_D:  r.nibble = 4'hD;
      CODE_E:  r.nibble = 4'hE;
      CODE_F:  r.nibble = 4'hF;
      default: r.error  = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q1_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Capture the raw lines, then re-time them through the second stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  // First-stage tap is the sample that becomes q_o on the next edge; a
  // comparison against it sees a change one cycle earlier than q_o does.
  assign q1_o = meta_q;
  assign q_o  = sync_q;

endmodule

// File: rtl/sevenseg_to_nibble.sv
// Glitch-filtered seven-segment to nibble decoder with valid/blank/error.
module sevenseg_to_nibble
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Nibble,
  output logic       o_Valid,
  output logic       o_Blank,
  output logic       o_Error
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

  logic [6:0]       seg_raw;
  logic [6:0]       seg_next;
  logic [6:0]       seg_s;
  logic             seg_same;
  decode_t          dec;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       accepted_q, accepted_d;
  logic [3:0]       nibble_q, nibble_d;
  logic             valid_q, valid_d;
  logic             blank_q, blank_d;
  logic             error_q, error_d;

  assign seg_raw = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                    i_Segment_E, i_Segment_F, i_Segment_G};

  sync_2ff #(.WIDTH(7)) u_sync (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .d_i    (seg_raw),
    .q1_o   (seg_next),
    .q_o    (seg_s)
  );

  // seg_next is the value s takes on the coming edge, so "s unchanged" is
  // judged one cycle ahead; this gives the STABLE_CYCLES+2 edge latency.
  assign seg_same = (seg_next == seg_s);
  assign dec      = decode_seg(seg_s);

  // Stability FSM: count matching samples, accept on entry to LOCKED.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accepted_d = accepted_q;
    nibble_d   = nibble_q;
    valid_d    = 1'b0;
    blank_d    = blank_q;
    error_d    = error_q;
    case (state_q)
      ST_SETTLE: begin
        if (!seg_same) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          cnt_d   = CNT_MAX;
          state_d = ST_LOCKED;
          if (seg_s != accepted_q) begin
            accepted_d = seg_s;
            if (seg_s == CODE_BLANK) begin
              blank_d = 1'b1;
              error_d = 1'b0;
            end else begin
              valid_d  = 1'b1;
              blank_d  = 1'b0;
              error_d  = dec.error;
              nibble_d = dec.error ? 4'h0 : dec.nibble;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (!seg_same) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
    endcase
  end

  // State, counter, accepted pattern and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= ST_SETTLE;
      cnt_q      <= '0;
      accepted_q <= CODE_BLANK;
      nibble_q   <= 4'h0;
      valid_q    <= 1'b0;
      blank_q    <= 1'b1;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      accepted_q <= accepted_d;
      nibble_q   <= nibble_d;
      valid_q    <= valid_d;
      blank_q    <= blank_d;
      error_q    <= error_d;
    end
  end

  assign o_Nibble = nibble_q;
  assign o_Valid  = valid_q;
  assign o_Blank  = blank_q;
  assign o_Error  = error_q;

endmodule
